// File: rtl/bank_pkg.sv
// Shared constants and types for the banked write-buffer pool.
package bank_pkg;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_ID_W       = $clog2(DEF_DEPTH);

  typedef logic [DEF_ID_W-1:0] entry_id_t;

endpackage

// File: rtl/bank_wbuf_alloc.sv
// Find-first-free priority encoder: lowest set bit of the free vector wins.
module bank_wbuf_alloc #(
  parameter int DEPTH = 32
) (
  input  logic [DEPTH-1:0]         free_vec,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int ID_W = $clog2(DEPTH);

  // Scan downward so the lowest free index is the last one assigned.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        found = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/bank_wbuf_pool.sv
// Pool of DEPTH write-buffer entries with allocate-on-write and read-and-free.
// Optional macro BANK_WBUF_PARITY_EN adds per-entry even parity and rd_perr_o.
module bank_wbuf_pool
  import bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  output logic [$clog2(DEPTH)-1:0] wr_id_o,
  input  logic                     rd_req_i,
  input  logic [$clog2(DEPTH)-1:0] rd_id_i,
  input  logic                     rd_release_i,
  output logic                     rd_valid_o,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
`ifdef BANK_WBUF_PARITY_EN
  output logic                     rd_perr_o,
`endif
  output logic [$clog2(DEPTH):0]   free_cnt_o,
  output logic                     err_o
);

  localparam int ID_W = $clog2(DEPTH);

  logic [DEPTH-1:0]      free_q;
  logic [ID_W:0]         cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  err_q;
  logic                  rd_vld_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  alloc_found;
  logic [ID_W-1:0]       alloc_id;
  logic                  wr_acc;
  logic                  rd_unalloc;
  logic                  rel_ok;

  bank_wbuf_alloc #(.DEPTH(DEPTH)) u_alloc (
    .free_vec (free_q),
    .found    (alloc_found),
    .idx      (alloc_id)
  );

  // An entry released this cycle is still marked allocated in free_q, so it
  // cannot be offered on wr_id_o until the following cycle.
  assign wr_ready_o = (cnt_q != '0);
  assign wr_id_o    = alloc_id;
  assign wr_acc     = wr_valid_i && wr_ready_o && alloc_found;
  assign rd_unalloc = rd_req_i && free_q[rd_id_i];
  assign rel_ok     = rd_req_i && rd_release_i && !free_q[rd_id_i];

  // Stage p0 -> p1: entry storage (never cleared) and registered read port.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[alloc_id] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      free_q     <= '1;
      cnt_q      <= (ID_W+1)'(DEPTH);
      err_q      <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      rd_vld_p1 <= rd_req_i;
      if (rd_req_i) rd_data_p1 <= mem_q[rd_id_i];
      if (rd_unalloc) err_q <= 1'b1;
      if (rel_ok) free_q[rd_id_i] <= 1'b1;
      if (wr_acc) free_q[alloc_id] <= 1'b0;
      cnt_q <= cnt_q - (ID_W+1)'(wr_acc) + (ID_W+1)'(rel_ok);
    end
  end

`ifdef BANK_WBUF_PARITY_EN
  logic par_q [DEPTH];
  logic rd_perr_p1;

  always_ff @(posedge clk_i) begin
    if (wr_acc) par_q[alloc_id] <= ^wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) rd_perr_p1 <= 1'b0;
    else        rd_perr_p1 <= rd_req_i && ((^mem_q[rd_id_i]) ^ par_q[rd_id_i]);
  end

  assign rd_perr_o = rd_perr_p1;
`endif

  assign rd_valid_o = rd_vld_p1;
  assign rd_data_o  = rd_data_p1;
  assign free_cnt_o = cnt_q;
  assign err_o      = err_q;

endmodule

// File: doc/bank_wbuf_pool.md
BANK_WBUF_POOL -- requirements
Module: bank_wbuf_pool

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 128, the entry data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, the entry count; legal values are powers of two from 2 to 64.
REQ-003 The block SHALL derive localparam ID_W = $clog2(DEPTH), not overridable.
REQ-004 clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-low.
REQ-006 wr_valid_i  input  1  write request carrying new data.
REQ-007 wr_ready_o  output  1  a free entry exists, so a write can be accepted.
REQ-008 wr_data_i  input  DATA_WIDTH  write data.
REQ-009 wr_id_o  output  ID_W  entry ID allocated to the write; meaningful while wr_ready_o=1.
REQ-010 rd_req_i  input  1  read request.
REQ-011 rd_id_i  input  ID_W  entry to read.
REQ-012 rd_release_i  input  1  free the entry when rd_req_i=1 (read-and-free).
REQ-013 rd_valid_o  output  1  rd_data_o valid.
REQ-014 rd_data_o  output  DATA_WIDTH  read data.
REQ-015 free_cnt_o  output  ID_W+1  number of free entries, 0..DEPTH.
REQ-016 err_o  output  1  sticky protocol error.

Function
REQ-017 A write SHALL be accepted only when wr_valid_i=1 and wr_ready_o=1; wr_ready_o = (free_cnt_o != 0).
REQ-018 wr_id_o SHALL be the lowest-index free entry, combinational from the free vector, and 0 when full.
REQ-019 On write acceptance, wr_data_i SHALL be stored at wr_id_o and that entry SHALL be marked allocated at the same edge.
REQ-020 On rd_req_i=1, rd_valid_o SHALL assert exactly 1 cycle later with rd_data_o = contents of rd_id_i as of the request cycle; fixed latency of 1.
REQ-021 rd_data_o SHALL hold its last value while rd_valid_o=0.
REQ-022 rd_req_i=1 with rd_release_i=1 SHALL free the entry at the same edge; the freed entry becomes allocatable from the next cycle.
REQ-023 A release in the same cycle as a write acceptance SHALL both take effect, with free_cnt_o net unchanged; the entry being released SHALL NOT appear on wr_id_o in that cycle.
REQ-024 A read of the entry being written in the same cycle SHALL return the previous contents; there is no bypass.
REQ-025 A read or release of an unallocated entry SHALL still produce rd_valid_o with stale data, SHALL NOT change free_cnt_o, and SHALL set err_o until reset.
REQ-026 free_cnt_o SHALL be a registered counter: -1 per accepted write, +1 per valid release, never outside 0..DEPTH.

Reset
REQ-027 With rst_i=0 at a clock edge: all entries free, free_cnt_o=DEPTH, wr_ready_o=1, wr_id_o=0, rd_valid_o=0, rd_data_o=0, err_o=0; storage contents are not cleared.
REQ-028 Reset asserted mid-operation SHALL discard any pending read, so rd_valid_o=0 in the cycle after reset, and SHALL drop all allocations.

Configuration
REQ-029 With macro BANK_WBUF_PARITY_EN defined: one even-parity bit is stored per entry, and output rd_perr_o (1 bit) asserts together with rd_valid_o on a parity mismatch; rd_perr_o resets to 0.
REQ-030 Without BANK_WBUF_PARITY_EN: no rd_perr_o port and no parity storage; all other behaviour is identical.

Structure
REQ-031 Default DATA_WIDTH and DEPTH constants and the entry-ID typedef SHALL live in the shared package bank_pkg.
REQ-032 The find-first-free priority encoder SHALL be the sub-module bank_wbuf_alloc (input DEPTH-bit free vector; outputs found flag and ID_W-bit index).

Verification
REQ-033 Reset, then 32 back-to-back writes -> wr_id_o 0..31 in order; free_cnt_o 31..0; wr_ready_o=0 after the 32nd.
REQ-034 Full pool, then read-and-free of ID 5 -> rd_valid_o next cycle with ID-5 data; free_cnt_o=1; wr_id_o=5 the following cycle.
REQ-035 Same cycle: write accepted to ID 2 and release of ID 7 with 10 free -> free_cnt_o stays 10; wr_id_o is not 7 in that cycle.
REQ-036 Release of never-written ID 3 -> err_o=1 and stays 1; free_cnt_o unchanged; clears only on rst_i=0.
REQ-037 rd_req_i pending when rst_i=0 -> rd_valid_o=0 next cycle; free_cnt_o=32.
REQ-038 BANK_WBUF_PARITY_EN defined, storage bit of ID 0 forced flipped -> read of ID 0 gives rd_perr_o=1 with rd_valid_o; a clean entry gives rd_perr_o=0.
